// File: rtl/wb_regfile_pkg.sv
// Shared definitions for the bexkat1 writeback sink: register-file geometry,
// writeback kind encoding and a small decode helper.
package bexkat1Def;

  localparam int NREGS = 16;
  localparam int AW    = $clog2(NREGS);
  localparam int SB_W  = 2;
  localparam int DW    = 32;

  typedef enum logic [1:0] {
    REG_WRITE_NONE = 2'b00,
    REG_WRITE_16   = 2'b01,
    REG_WRITE_RSVD = 2'b10,
    REG_WRITE_32   = 2'b11
  } reg_write_t;

  // A retiring write is one that updates the register file and frees a scoreboard slot.
  function automatic logic is_retiring(input reg_write_t kind);
    return (kind == REG_WRITE_16) || (kind == REG_WRITE_32);
  endfunction

endpackage

// File: rtl/wb_sb_counter.sv
// One scoreboard slot: saturating up/down count of in-flight writers to a single
// register, with a flush clear and single-cycle overflow/underflow flags.
module wb_sb_counter
  import bexkat1Def::*;
#(
  parameter int W = SB_W
) (
  input  logic         clk_i,
  input  logic         rst_n_i,
  input  logic         en_i,
  input  logic         clr_i,
  input  logic         inc_i,
  input  logic         dec_i,
  output logic [W-1:0] count_o,
  output logic         ovf_o,
  output logic         udf_o
);

  localparam logic [W-1:0] MAX = '1;

  logic [W-1:0] count_q, count_d;

  // NOTE: every output of this block gets a default first so no latch is inferred.
  always_comb begin
    count_d = count_q;
    ovf_o   = 1'b0;
    udf_o   = 1'b0;
    if (en_i) begin
      if (inc_i && !dec_i) begin
        if (count_q == MAX) ovf_o = 1'b1;
        else                count_d = count_q + 1'b1;
      end else if (dec_i && !inc_i) begin
        if (count_q == '0) udf_o = 1'b1;
        else               count_d = count_q - 1'b1;
      end
      // The retiring write is still checked, but a flush leaves nothing in flight.
      if (clr_i) count_d = '0;
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops update together.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) count_q <= '0;
    else          count_q <= count_d;
  end

  assign count_o = count_q;

endmodule

// File: rtl/wb_regfile.sv
// Writeback sink: commits WB results to the architectural register file, serves two
// bypassed read ports and a pending-writer scoreboard to decode, holds sticky halt/error.
module wb_regfile
  import bexkat1Def::*;
#(
  parameter int NR  = NREGS,
  parameter int SBW = SB_W
) (
  input  logic                   clk_i,
  input  logic                   rst_n_i,
  input  logic [1:0]             reg_write_i,
  input  logic [$clog2(NR)-1:0]  reg_write_addr_i,
  input  logic [DW-1:0]          result_i,
  input  logic                   pc_set_i,
  input  logic                   halt_i,
  input  logic                   issue_i,
  input  logic [$clog2(NR)-1:0]  issue_addr_i,
  input  logic [$clog2(NR)-1:0]  rd_addr_a_i,
  input  logic [$clog2(NR)-1:0]  rd_addr_b_i,
  output logic [DW-1:0]          rd_data_a_o,
  output logic [DW-1:0]          rd_data_b_o,
  output logic                   busy_a_o,
  output logic                   busy_b_o,
  output logic                   halted_o,
  output logic                   err_o
);

  localparam int RAW = $clog2(NR);

  reg_write_t      kind;
  logic            active;
  logic            wr_en;
  logic [DW-1:0]   wr_data;
  logic [DW-1:0]   regs_q [NR];
  logic [SBW-1:0]  cnt    [NR];
  logic [NR-1:0]   ovf, udf;
  logic            halted_q, halted_d;
  logic            err_q, err_d;

  assign kind    = reg_write_t'(reg_write_i);
  assign active  = !halted_q;
  assign wr_en   = active && is_retiring(kind);
  assign wr_data = (kind == REG_WRITE_32) ? result_i
                                          : {regs_q[reg_write_addr_i][DW-1:16], result_i[15:0]};

  // NOTE: the register array sits under reset because architectural state must read 0 after reset.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int r = 0; r < NR; r++) regs_q[r] <= '0;
    end else if (wr_en) begin
      regs_q[reg_write_addr_i] <= wr_data;
    end
  end

  for (genvar i = 0; i < NR; i++) begin : g_sb
    localparam logic [RAW-1:0] IDX = RAW'(i);
    wb_sb_counter #(.W(SBW)) u_cnt (
      .clk_i   (clk_i),
      .rst_n_i (rst_n_i),
      .en_i    (active),
      .clr_i   (pc_set_i),
      .inc_i   (issue_i && !pc_set_i && (issue_addr_i == IDX)),
      .dec_i   (wr_en && (reg_write_addr_i == IDX)),
      .count_o (cnt[i]),
      .ovf_o   (ovf[i]),
      .udf_o   (udf[i])
    );
  end

  // Reads see the post-commit value; a retiring writer to the read register does not stall.
  always_comb begin
    logic hit_a, hit_b;
    hit_a       = wr_en && (reg_write_addr_i == rd_addr_a_i);
    hit_b       = wr_en && (reg_write_addr_i == rd_addr_b_i);
    rd_data_a_o = hit_a ? wr_data : regs_q[rd_addr_a_i];
    rd_data_b_o = hit_b ? wr_data : regs_q[rd_addr_b_i];
    busy_a_o    = (cnt[rd_addr_a_i] - {{(SBW-1){1'b0}}, hit_a}) != '0;
    busy_b_o    = (cnt[rd_addr_b_i] - {{(SBW-1){1'b0}}, hit_b}) != '0;
  end

  always_comb begin
    halted_d = halted_q | (active && halt_i);
    err_d    = err_q | (active && ((kind == REG_WRITE_RSVD) || (|ovf) || (|udf)));
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      halted_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      halted_q <= halted_d;
      err_q    <= err_d;
    end
  end

  assign halted_o = halted_q;
  assign err_o    = err_q;

endmodule

// File: tb/tb_wb_regfile.sv
// Directed and randomized bench for wb_regfile against a behavioural model of the
// register file, scoreboard counts and sticky flags.
module tb_wb_regfile;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  reg_write;
  logic [3:0]  reg_write_addr;
  logic [31:0] result;
  logic        pc_set, halt, issue;
  logic [3:0]  issue_addr, rd_addr_a, rd_addr_b;
  logic [31:0] rd_data_a, rd_data_b;
  logic        busy_a, busy_b, halted, err;

  int vectors     = 0;
  int miscompares = 0;

  logic [31:0] m_regs [16];
  int          m_cnt  [16];
  bit          m_halted, m_err;

  always #5 clk = ~clk;

  wb_regfile dut (
    .clk_i            (clk),
    .rst_n_i          (rst_n),
    .reg_write_i      (reg_write),
    .reg_write_addr_i (reg_write_addr),
    .result_i         (result),
    .pc_set_i         (pc_set),
    .halt_i           (halt),
    .issue_i          (issue),
    .issue_addr_i     (issue_addr),
    .rd_addr_a_i      (rd_addr_a),
    .rd_addr_b_i      (rd_addr_b),
    .rd_data_a_o      (rd_data_a),
    .rd_data_b_o      (rd_data_b),
    .busy_a_o         (busy_a),
    .busy_b_o         (busy_b),
    .halted_o         (halted),
    .err_o            (err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic bit m_writes();
    return !m_halted && (reg_write == 2'b01 || reg_write == 2'b11);
  endfunction

  function automatic logic [31:0] m_read(input logic [3:0] a);
    if (m_writes() && reg_write_addr == a)
      return (reg_write == 2'b11) ? result : {m_regs[a][31:16], result[15:0]};
    return m_regs[a];
  endfunction

  function automatic logic m_busy(input logic [3:0] a);
    int dec;
    dec = (m_writes() && reg_write_addr == a) ? 1 : 0;
    return ((m_cnt[a] - dec) & 3) != 0;
  endfunction

  task automatic m_reset();
    for (int r = 0; r < 16; r++) begin
      m_regs[r] = '0;
      m_cnt[r]  = 0;
    end
    m_halted = 0;
    m_err    = 0;
  endtask

  task automatic m_clock();
    if (m_halted) return;
    if (reg_write == 2'b10) m_err = 1;
    for (int r = 0; r < 16; r++) begin
      bit inc, dec;
      inc = issue && issue_addr == 4'(r) && !pc_set;
      dec = m_writes() && reg_write_addr == 4'(r);
      if (inc && !dec) begin
        if (m_cnt[r] == 3) m_err = 1; else m_cnt[r]++;
      end else if (dec && !inc) begin
        if (m_cnt[r] == 0) m_err = 1; else m_cnt[r]--;
      end
      if (pc_set) m_cnt[r] = 0;
    end
    if (m_writes()) m_regs[reg_write_addr] = m_read(reg_write_addr);
    if (halt) m_halted = 1;
  endtask

  task automatic drive(input logic [1:0] k, input logic [3:0] wa, input logic [31:0] res,
                       input logic pcs, input logic hlt, input logic iss, input logic [3:0] ia,
                       input logic [3:0] ra, input logic [3:0] rb);
    reg_write = k; reg_write_addr = wa; result = res; pc_set = pcs; halt = hlt;
    issue = iss; issue_addr = ia; rd_addr_a = ra; rd_addr_b = rb;
  endtask

  // Inputs are already applied; compare combinational outputs, clock, compare flags.
  task automatic step(input string tag);
    #1;
    check({tag, ".rd_a"},   rd_data_a, m_read(rd_addr_a));
    check({tag, ".rd_b"},   rd_data_b, m_read(rd_addr_b));
    check({tag, ".busy_a"}, 32'(busy_a), 32'(m_busy(rd_addr_a)));
    check({tag, ".busy_b"}, 32'(busy_b), 32'(m_busy(rd_addr_b)));
    @(posedge clk);
    m_clock();
    #1;
    check({tag, ".err"},    32'(err),    32'(m_err));
    check({tag, ".halted"}, 32'(halted), 32'(m_halted));
  endtask

  task automatic idle();
    drive(2'b00, 4'd0, 32'd0, 0, 0, 0, 4'd0, 4'd0, 4'd0);
  endtask

  task automatic do_reset();
    idle();
    rst_n = 1'b0;
    #2;
    m_reset();
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    idle();
    m_reset();
    #3;
    check("reset.rd_a",   rd_data_a, 32'd0);
    check("reset.busy_a", 32'(busy_a), 32'd0);
    check("reset.halted", 32'(halted), 32'd0);
    check("reset.err",    32'(err),    32'd0);
    #9 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // 1: full-word commit with same-cycle bypass; issue first so the scoreboard stays clean
    drive(2'b00, 4'd0, 32'd0, 0, 0, 1, 4'd3, 4'd3, 4'd3);  step("t1.iss");
    drive(2'b00, 4'd0, 32'd0, 0, 0, 1, 4'd3, 4'd3, 4'd3);  step("t1.iss2");
    drive(2'b11, 4'd3, 32'hDEADBEEF, 0, 0, 0, 4'd0, 4'd3, 4'd0);
    #1 check("t1.bypass", rd_data_a, 32'hDEADBEEF);
    step("t1.commit");
    idle(); rd_addr_a = 4'd3;
    #1 check("t1.held", rd_data_a, 32'hDEADBEEF);
    step("t1.after");

    // 2: halfword merge, bypassed in the commit cycle
    drive(2'b01, 4'd3, 32'h12345678, 0, 0, 0, 4'd0, 4'd3, 4'd3);
    #1 check("t2.bypass", rd_data_b, 32'hDEAD5678);
    step("t2.commit");
    idle(); rd_addr_a = 4'd3;
    #1 check("t2.held", rd_data_a, 32'hDEAD5678);
    check("t2.err", 32'(err), 32'd0);
    step("t2.after");

    // 3: busy tracking with the final retiring write not stalling
    drive(2'b00, 4'd0, 32'd0, 0, 0, 1, 4'd5, 4'd5, 4'd0);  step("t3.iss1");
    drive(2'b00, 4'd0, 32'd0, 0, 0, 1, 4'd5, 4'd5, 4'd0);  step("t3.iss2");
    idle(); rd_addr_a = 4'd5;
    #1 check("t3.busy2", 32'(busy_a), 32'd1);
    step("t3.read");
    drive(2'b11, 4'd5, 32'hA5A5_0001, 0, 0, 0, 4'd0, 4'd5, 4'd5);
    #1 check("t3.busy_c1", 32'(busy_a), 32'd1);
    step("t3.c1");
    drive(2'b11, 4'd5, 32'hA5A5_0002, 0, 0, 0, 4'd0, 4'd5, 4'd5);
    #1 check("t3.busy_c2", 32'(busy_a), 32'd0);
    step("t3.c2");

    // 4: overflow then underflow, both sticky
    do_reset();
    for (int n = 0; n < 4; n++) begin
      drive(2'b00, 4'd0, 32'd0, 0, 0, 1, 4'd7, 4'd7, 4'd7);
      step("t4.iss");
      if (n == 2) check("t4.err_pre", 32'(err), 32'd0);
    end
    check("t4.err_ovf", 32'(err), 32'd1);
    drive(2'b11, 4'd0, 32'h0000_0042, 0, 0, 0, 4'd0, 4'd0, 4'd7);  step("t4.udf");
    check("t4.err_sticky", 32'(err), 32'd1);

    // 5: flush clears every count and squashes a same-cycle issue
    do_reset();
    drive(2'b00, 4'd0, 32'd0, 0, 0, 1, 4'd1, 4'd1, 4'd2);  step("t5.i1a");
    drive(2'b00, 4'd0, 32'd0, 0, 0, 1, 4'd1, 4'd1, 4'd2);  step("t5.i1b");
    drive(2'b00, 4'd0, 32'd0, 0, 0, 1, 4'd2, 4'd1, 4'd2);  step("t5.i2");
    drive(2'b11, 4'd1, 32'hCAFE_F00D, 1, 0, 1, 4'd4, 4'd1, 4'd2);  step("t5.flush");
    idle(); rd_addr_a = 4'd1; rd_addr_b = 4'd2;
    #1 check("t5.busy_r1", 32'(busy_a), 32'd0);
    check("t5.busy_r2", 32'(busy_b), 32'd0);
    check("t5.r1", rd_data_a, 32'hCAFE_F00D);
    step("t5.post");
    idle(); rd_addr_a = 4'd4;
    #1 check("t5.busy_r4", 32'(busy_a), 32'd0);
    step("t5.post4");

    // 6: halt retires with its write; later activity ignored; async reset clears at once
    do_reset();
    drive(2'b00, 4'd0, 32'd0, 0, 0, 1, 4'd9, 4'd9, 4'd9);  step("t6.iss");
    drive(2'b11, 4'd9, 32'h55, 0, 1, 0, 4'd0, 4'd9, 4'd9);  step("t6.halt");
    check("t6.halted", 32'(halted), 32'd1);
    drive(2'b11, 4'd9, 32'h66, 0, 0, 1, 4'd9, 4'd9, 4'd9);  step("t6.ignored");
    idle(); rd_addr_a = 4'd9;
    #1 check("t6.r9", rd_data_a, 32'h55);
    check("t6.err", 32'(err), 32'd0);
    #2 rst_n = 1'b0;
    #1 check("t6.rst_halted", 32'(halted), 32'd0);
    check("t6.rst_r9", rd_data_a, 32'd0);
    m_reset();
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Randomized traffic against the model
    for (int c = 0; c < 400; c++) begin
      int      sel;
      logic [1:0] k;
      sel = $urandom_range(0, 9);
      k   = (sel < 3) ? 2'b00 : (sel < 6) ? 2'b01 : (sel < 9) ? 2'b11 : 2'b10;
      drive(k, 4'($urandom_range(0, 15)), $urandom, ($urandom_range(0, 19) == 0), 1'b0,
            1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
            4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
      if ($urandom_range(0, 7) == 0) rd_addr_a = reg_write_addr;
      if ($urandom_range(0, 7) == 0) rd_addr_b = rd_addr_a;
      step("rand");
      if (c == 200) do_reset();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
